// File: rtl/tx_response_ctrl_if.sv
// Bundle of the request strobes and the byte-wide TX handshake of tx_response_ctrl.
// slave: the controller side; master: the side driving requests and consuming TX bytes.
interface tx_response_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0]   RdData;
  logic               RdData_Valid;
  logic [2*WIDTH-1:0] ALU_OUT;
  logic               OUT_Valid;
  logic               Tx_Full;
  logic [WIDTH-1:0]   TX_P_Data;
  logic               TX_D_VLD;
  logic               Drop_Err;
  logic               Ctrl_Busy;

  modport slave (
    input  RdData, RdData_Valid, ALU_OUT, OUT_Valid, Tx_Full,
    output TX_P_Data, TX_D_VLD, Drop_Err, Ctrl_Busy
  );

  modport master (
    output RdData, RdData_Valid, ALU_OUT, OUT_Valid, Tx_Full,
    input  TX_P_Data, TX_D_VLD, Drop_Err, Ctrl_Busy
  );
endinterface

// File: rtl/tx_response_ctrl.sv
// Round-robin arbiter sharing one byte-wide TX path between register read bytes and ALU results.
// Define TX_CTRL_FRAME_EN to prefix each response with a tag byte (A5 read, 5A ALU).
module tx_response_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic               CLK,
  input logic               Reset,
  tx_response_ctrl_if.slave bus
);

`ifdef TX_CTRL_FRAME_EN
  typedef enum logic [2:0] {StIdle, StSendRd, StSendLo, StSendHi, StSendTag} state_e;
  localparam logic [WIDTH-1:0] TagRd  = WIDTH'(8'hA5);
  localparam logic [WIDTH-1:0] TagAlu = WIDTH'(8'h5A);
`else
  typedef enum logic [1:0] {StIdle, StSendRd, StSendLo, StSendHi} state_e;
`endif

  state_e               r_state;
  logic [WIDTH-1:0]     r_rd_buf;
  logic [2*WIDTH-1:0]   r_alu_buf;
  logic                 r_rd_pend;
  logic                 r_alu_pend;
  logic                 r_last_alu;
  logic [WIDTH-1:0]     r_tx_data;
  logic                 r_tx_vld;
  logic                 r_drop;
`ifdef TX_CTRL_FRAME_EN
  logic                 r_tag_alu;
`endif

  logic w_accept;
  logic w_rd_done;
  logic w_alu_done;
  logic w_rd_cap;
  logic w_alu_cap;
  logic w_grant_rd;
  logic w_grant_alu;

  assign w_accept   = r_tx_vld & ~bus.Tx_Full;
  assign w_rd_done  = w_accept & (r_state == StSendRd);
  assign w_alu_done = w_accept & (r_state == StSendHi);

  // A full slot may be refilled on the edge its final byte leaves.
  assign w_rd_cap  = bus.RdData_Valid & (~r_rd_pend | w_rd_done);
  assign w_alu_cap = bus.OUT_Valid & (~r_alu_pend | w_alu_done);

  assign w_grant_rd  = r_rd_pend & (~r_alu_pend | r_last_alu);
  assign w_grant_alu = r_alu_pend & (~r_rd_pend | ~r_last_alu);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state    <= StIdle;
      r_rd_buf   <= '0;
      r_alu_buf  <= '0;
      r_rd_pend  <= 1'b0;
      r_alu_pend <= 1'b0;
      r_last_alu <= 1'b1;
      r_tx_data  <= '0;
      r_tx_vld   <= 1'b0;
      r_drop     <= 1'b0;
`ifdef TX_CTRL_FRAME_EN
      r_tag_alu  <= 1'b0;
`endif
    end else begin
      r_drop <= (bus.RdData_Valid & ~w_rd_cap) | (bus.OUT_Valid & ~w_alu_cap);

      if (w_rd_cap) begin
        r_rd_buf  <= bus.RdData;
        r_rd_pend <= 1'b1;
      end else if (w_rd_done) begin
        r_rd_pend <= 1'b0;
      end

      if (w_alu_cap) begin
        r_alu_buf  <= bus.ALU_OUT;
        r_alu_pend <= 1'b1;
      end else if (w_alu_done) begin
        r_alu_pend <= 1'b0;
      end

      case (r_state)
        StIdle: begin
          r_tx_vld <= 1'b0;
`ifdef TX_CTRL_FRAME_EN
          if (w_grant_rd) begin
            r_state   <= StSendTag;
            r_tag_alu <= 1'b0;
            r_tx_data <= TagRd;
            r_tx_vld  <= 1'b1;
          end else if (w_grant_alu) begin
            r_state   <= StSendTag;
            r_tag_alu <= 1'b1;
            r_tx_data <= TagAlu;
            r_tx_vld  <= 1'b1;
          end
`else
          if (w_grant_rd) begin
            r_state   <= StSendRd;
            r_tx_data <= r_rd_buf;
            r_tx_vld  <= 1'b1;
          end else if (w_grant_alu) begin
            r_state   <= StSendLo;
            r_tx_data <= r_alu_buf[WIDTH-1:0];
            r_tx_vld  <= 1'b1;
          end
`endif
        end
`ifdef TX_CTRL_FRAME_EN
        StSendTag: begin
          if (w_accept) begin
            if (r_tag_alu) begin
              r_state   <= StSendLo;
              r_tx_data <= r_alu_buf[WIDTH-1:0];
            end else begin
              r_state   <= StSendRd;
              r_tx_data <= r_rd_buf;
            end
          end
        end
`endif
        StSendRd: begin
          if (w_accept) begin
            r_state    <= StIdle;
            r_tx_vld   <= 1'b0;
            r_last_alu <= 1'b0;
          end
        end
        StSendLo: begin
          if (w_accept) begin
            r_state   <= StSendHi;
            r_tx_data <= r_alu_buf[2*WIDTH-1:WIDTH];
          end
        end
        StSendHi: begin
          if (w_accept) begin
            r_state    <= StIdle;
            r_tx_vld   <= 1'b0;
            r_last_alu <= 1'b1;
          end
        end
        default: begin
          r_state  <= StIdle;
          r_tx_vld <= 1'b0;
        end
      endcase
    end
  end

  assign bus.TX_P_Data = r_tx_data;
  assign bus.TX_D_VLD  = r_tx_vld;
  assign bus.Drop_Err  = r_drop;
  assign bus.Ctrl_Busy = (r_state != StIdle) | r_rd_pend | r_alu_pend;

endmodule
